pwm_step_ctrl: RTL
==================

PWM_STEP_CTRL -- requirements
Module: pwm_step_ctrl

Interface
REQ-001 The module SHALL have parameter PWM_BITS, default 8, giving the counter and duty width N.
REQ-002 The module SHALL have parameter STEP, default 16, giving the duty change applied per accepted button pulse.
REQ-003 The module SHALL derive local constant MAX = 2^N - 1, the full-on duty value and the number of ticks per period.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port UP_PULSE, input, 1 bit: one-CLK pulse from the debounce/edge stage requesting a duty increase.
REQ-007 The module SHALL have port DOWN_PULSE, input, 1 bit: one-CLK pulse from the debounce/edge stage requesting a duty decrease.
REQ-008 The module SHALL have port PWM_enable, input, 1 bit: one-CLK tick from the prescaler; each tick advances the PWM counter once.
REQ-009 The module SHALL have port PWM_OUT, output, 1 bit: the registered PWM waveform.
REQ-010 The module SHALL have port DUTY, output, N bits: the active duty value.
REQ-011 The module SHALL have port PERIOD_END, output, 1 bit: one-CLK pulse marking a period wrap.
REQ-012 The module SHALL have port PENDING, output, 1 bit: high while the requested duty differs from the active duty.

Function
REQ-013 The module SHALL hold a requested-duty register duty_req (N bits) and an active-duty register duty_act (N bits); DUTY SHALL equal duty_act.
REQ-014 On UP_PULSE=1 with DOWN_PULSE=0, the module SHALL set duty_req to min(duty_req + STEP, MAX), computing the sum at N+1 bits so it cannot wrap.
REQ-015 On DOWN_PULSE=1 with UP_PULSE=0, the module SHALL set duty_req to max(duty_req - STEP, 0), with no underflow wrap.
REQ-016 When UP_PULSE and DOWN_PULSE are both 1 in the same cycle, the module SHALL leave duty_req unchanged.
REQ-017 The module SHALL update duty_req independently of PWM_enable.
REQ-018 The module SHALL keep counter cnt (N bits) in the range 0..MAX-1.
REQ-019 On PWM_enable=1 the module SHALL increment cnt; with PWM_enable=0, cnt SHALL hold.
REQ-020 When PWM_enable=1 and cnt=MAX-1 (wrap), the module SHALL set cnt to 0 and load duty_act with duty_req as it stood before that edge.
REQ-021 A pulse arriving in the wrap cycle SHALL update duty_req only and SHALL take effect at the following wrap.
REQ-022 The module SHALL change duty_act only at a wrap, so no period ever contains a mix of two duty values.
REQ-023 The module SHALL register PWM_OUT every CLK as (cnt < duty_act), using pre-edge values, giving one CLK of latency from cnt/duty_act to PWM_OUT.
REQ-024 With duty_act=0, PWM_OUT SHALL be constantly 0; with duty_act=MAX, PWM_OUT SHALL be constantly 1.
REQ-025 The high time per period SHALL equal exactly duty_act PWM_enable ticks out of MAX ticks.
REQ-026 PERIOD_END SHALL be registered and SHALL be 1 in the single CLK following each wrap edge, otherwise 0.
REQ-027 PENDING SHALL be registered and SHALL equal (duty_req != duty_act) evaluated on post-update values, one CLK after the change.

Reset
REQ-028 While RST_N=0, the module SHALL immediately force duty_req=0, duty_act=0, cnt=0, PWM_OUT=0, PERIOD_END=0 and PENDING=0, independent of CLK.
REQ-029 Reset asserted mid-period SHALL abort that period; after release, operation SHALL resume from cnt=0 with no stale pulses or pending duty retained.
REQ-030 The module SHALL ignore pulses and ticks while RST_N=0.

Verification (PWM_BITS=8, STEP=16, MAX=255)
REQ-031 The bench SHALL apply reset, then one UP_PULSE, then continuous PWM_enable, and check: PENDING=1 until the first wrap; DUTY=16 after it; next period PWM_OUT high for exactly 16 ticks and low for 239.
REQ-032 The bench SHALL apply 17 UP_PULSEs and check duty_req saturates at 255; after the wrap, PWM_OUT SHALL stay 1 across a full period and a further UP_PULSE SHALL leave DUTY=255.
REQ-033 The bench SHALL apply a DOWN_PULSE from 0 and check DUTY stays 0 and PWM_OUT stays 0; from DUTY=8 a DOWN_PULSE SHALL give 0, not 248.
REQ-034 The bench SHALL assert UP_PULSE and DOWN_PULSE together from DUTY=32 and check duty_req=32 and PENDING stays 0.
REQ-035 The bench SHALL assert UP_PULSE exactly in the wrap cycle from DUTY=32 and check DUTY stays 32 for the next period, becomes 48 at the following wrap, and PERIOD_END pulses once per wrap.
REQ-036 The bench SHALL drop RST_N mid-period with DUTY=64 and cnt=100, and check all outputs are 0 immediately; after release with no pulses, PWM_OUT SHALL stay 0 for a full period.

Source files
------------

// File: rtl/pwm_step_ctrl.sv
// PWM generator with button-stepped duty; the requested duty is
// promoted to the active duty only at a period wrap (glitch-free).
module pwm_step_ctrl #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                UP_PULSE,
    input  logic                DOWN_PULSE,
    input  logic                PWM_enable,
    output logic                PWM_OUT,
    output logic [PWM_BITS-1:0] DUTY,
    output logic                PERIOD_END,
    output logic                PENDING
);

    localparam int N = PWM_BITS;
    localparam logic [N-1:0] MAX    = {N{1'b1}};
    localparam logic [N:0]   MAX_W  = {1'b0, MAX};
    localparam logic [N:0]   STEP_W = STEP[N:0];
    localparam logic [N-1:0] ONE    = N'(1);

    logic [N-1:0] duty_req;
    logic [N-1:0] duty_act;
    logic [N-1:0] cnt;
    logic [N-1:0] req_nxt;
    logic [N-1:0] act_nxt;
    logic [N-1:0] cnt_nxt;
    logic [N:0]   sum_up;
    logic         wrap;

    always_comb begin
        sum_up  = {1'b0, duty_req} + STEP_W;
        wrap    = PWM_enable && (cnt == MAX - ONE);
        req_nxt = duty_req;
        cnt_nxt = cnt;
        act_nxt = duty_act;

        // Sum carries one extra bit so saturation is detected, not wrapped
        unique case (1'b1)
            (UP_PULSE && !DOWN_PULSE):
                req_nxt = (sum_up > MAX_W) ? MAX : sum_up[N-1:0];
            (DOWN_PULSE && !UP_PULSE):
                req_nxt = ({1'b0, duty_req} < STEP_W) ? '0
                        : duty_req - STEP_W[N-1:0];
            default:
                req_nxt = duty_req;
        endcase

        if (wrap) begin
            cnt_nxt = '0;
            act_nxt = duty_req;
        end else if (PWM_enable) begin
            cnt_nxt = cnt + ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            duty_req   <= '0;
            duty_act   <= '0;
            cnt        <= '0;
            PWM_OUT    <= 1'b0;
            PERIOD_END <= 1'b0;
            PENDING    <= 1'b0;
        end else begin
            duty_req   <= req_nxt;
            duty_act   <= act_nxt;
            cnt        <= cnt_nxt;
            PWM_OUT    <= (cnt < duty_act);
            PERIOD_END <= wrap;
            PENDING    <= (req_nxt != act_nxt);
        end
    end

    assign DUTY = duty_act;

endmodule
